// File: rtl/ascon_pack.sv
// Shared Ascon definitions: the 5x64-bit state type and the 5-bit S-box table.
package ascon_pack;

  typedef logic [4:0][63:0] type_state;

  localparam logic [4:0] SBOX_TABLE [32] = '{
    5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
  };

endpackage

// File: rtl/ps_sbox.sv
// Single-column Ascon S-box, combinational. PS_SBOX_LUT_EN selects the table
// lookup; otherwise the bit-sliced Boolean equations are used.
module sbox (
  input  logic [4:0] x_i,
  output logic [4:0] y_o
);

`ifdef PS_SBOX_LUT_EN
  import ascon_pack::*;

  assign y_o = SBOX_TABLE[x_i];
`else
  logic a0, a1, a2, a3, a4;
  logic t0, t1, t2, t3, t4;

  // x_i[4] carries word S0, so a0 is the MSB of the column value
  always_comb begin
    a0 = x_i[4];
    a1 = x_i[3];
    a2 = x_i[2];
    a3 = x_i[1];
    a4 = x_i[0];

    a0 = a0 ^ a4;
    a4 = a4 ^ a3;
    a2 = a2 ^ a1;

    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;

    a0 = a0 ^ t1;
    a1 = a1 ^ t2;
    a2 = a2 ^ t3;
    a3 = a3 ^ t4;
    a4 = a4 ^ t0;

    a1 = a1 ^ a0;
    a0 = a0 ^ a4;
    a3 = a3 ^ a2;
    a2 = ~a2;

    y_o = {a0, a1, a2, a3, a4};
  end
`endif

endmodule

// File: rtl/ps.sv
// Ascon p_S substitution layer: 64 parallel column S-boxes, one register stage.
// Build option PS_SBOX_LUT_EN (handled inside sbox) picks LUT vs equations.
module ps
  import ascon_pack::*;
(
  input  logic      clock_i,
  input  logic      resetb_i,
  input  logic      valid_i,
  input  type_state state_i,
  output type_state substitution_o,
  output logic      valid_o
);

  type_state substitution_d;
  type_state substitution_q;
  logic      valid_q;

  for (genvar j = 0; j < 64; j++) begin : g_col
    logic [4:0] col_x;
    logic [4:0] col_y;

    assign col_x = {state_i[0][j], state_i[1][j], state_i[2][j],
                    state_i[3][j], state_i[4][j]};

    sbox u_sbox (
      .x_i (col_x),
      .y_o (col_y)
    );

    assign substitution_d[0][j] = col_y[4];
    assign substitution_d[1][j] = col_y[3];
    assign substitution_d[2][j] = col_y[2];
    assign substitution_d[3][j] = col_y[1];
    assign substitution_d[4][j] = col_y[0];
  end

  // Load gated by valid_i so an undriven state_i never reaches the register
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      substitution_q <= '0;
      valid_q        <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        substitution_q <= substitution_d;
      end
    end
  end

  assign substitution_o = substitution_q;
  assign valid_o        = valid_q;

endmodule

// File: tb/tb_ps.sv
// Scoreboard bench for ps: table-based column model, randomized and directed traffic.
module tb_ps;
  import ascon_pack::*;

  logic      clock_i  = 1'b0;
  logic      resetb_i = 1'b0;
  logic      valid_i  = 1'b0;
  type_state state_i  = '0;
  type_state substitution_o;
  logic      valid_o;

  always #5 clock_i = ~clock_i;

  ps dut (
    .clock_i        (clock_i),
    .resetb_i       (resetb_i),
    .valid_i        (valid_i),
    .state_i        (state_i),
    .substitution_o (substitution_o),
    .valid_o        (valid_o)
  );

  localparam logic [4:0] REF_SBOX [32] = '{
    5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
  };

  int        n_pass  = 0;
  int        n_total = 0;
  logic      vq[$];
  type_state dq[$];
  type_state last_exp = '0;
  logic      mon_v;
  type_state mon_e;

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic type_state ref_ps(input type_state s);
    type_state  r;
    logic [4:0] x, y;
    for (int j = 0; j < 64; j++) begin
      x = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
      y = REF_SBOX[x];
      r[0][j] = y[4]; r[1][j] = y[3]; r[2][j] = y[2]; r[3][j] = y[1]; r[4][j] = y[0];
    end
    return r;
  endfunction

  function automatic type_state mk(input logic [63:0] w0, w1, w2, w3, w4);
    type_state s;
    s[0] = w0; s[1] = w1; s[2] = w2; s[3] = w3; s[4] = w4;
    return s;
  endfunction

  function automatic type_state rnd_state();
    type_state s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom(), $urandom()};
    return s;
  endfunction

  // Drive one cycle; expected output is queued for the monitor
  task automatic drive(input logic v, input type_state s, input type_state e);
    @(posedge clock_i);
    #4;
    valid_i = v;
    state_i = v ? s : rnd_state();
    vq.push_back(v);
    if (v) dq.push_back(e);
  endtask

  task automatic drive_m(input logic v, input type_state s);
    drive(v, s, ref_ps(s));
  endtask

  // Monitor: one expectation per cycle, sampled between edges
  always @(posedge clock_i) begin
    #3;
    if (!resetb_i) begin
      last_exp = '0;
    end else if (vq.size() == 0) begin
      chk("valid_o_idle", {319'd0, valid_o}, 320'd0);
      chk("hold_idle", substitution_o, last_exp);
    end else begin
      mon_v = vq.pop_front();
      chk("valid_o", {319'd0, valid_o}, {319'd0, mon_v});
      if (mon_v) begin
        mon_e = (dq.size() != 0) ? dq.pop_front() : last_exp;
        chk("data", substitution_o, mon_e);
        last_exp = mon_e;
      end else begin
        chk("hold", substitution_o, last_exp);
      end
    end
  end

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    type_state s;
    #2;
    chk("rst_data", substitution_o, '0);
    chk("rst_valid", {319'd0, valid_o}, 320'd0);
    #10 resetb_i = 1'b1;

    drive(1'b1, mk(0, 0, 0, 0, 0), mk(0, 0, ONES, 0, 0));
    drive(1'b1, mk(ONES, ONES, ONES, ONES, ONES), mk(ONES, 0, ONES, ONES, ONES));
    drive(1'b1, mk(0, 0, 0, 0, 64'd1), mk(0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'd1));
    drive_m(1'b1, mk(64'h00001000808C0001, 64'h6CB10AD9CA912F80, 64'h691AED630E8190EF,
                     64'h0C4C36A20853217C, 64'h46487B3E06D9D7A8));

    for (int x = 0; x < 32; x++) begin
      logic [4:0] xv, yv;
      xv = 5'(x);
      yv = REF_SBOX[xv];
      drive(1'b1, mk({64{xv[4]}}, {64{xv[3]}}, {64{xv[2]}}, {64{xv[1]}}, {64{xv[0]}}),
                  mk({64{yv[4]}}, {64{yv[3]}}, {64{yv[2]}}, {64{yv[1]}}, {64{yv[0]}}));
    end

    drive(1'b0, '0, '0);
    drive(1'b0, '0, '0);

    for (int i = 0; i < 200; i++) drive_m(($urandom_range(0, 3) != 0), rnd_state());

    // Reset between edges while a result is in flight
    drive_m(1'b1, rnd_state());
    #2;
    resetb_i = 1'b0;
    valid_i  = 1'b0;
    vq.delete();
    dq.delete();
    #1;
    chk("rst_mid_data", substitution_o, '0);
    chk("rst_mid_valid", {319'd0, valid_o}, 320'd0);
    repeat (2) @(posedge clock_i);
    #6 resetb_i = 1'b1;

    s = rnd_state();
    drive_m(1'b1, s);
    for (int i = 0; i < 20; i++) drive_m(($urandom_range(0, 1) != 0), rnd_state());
    repeat (3) drive(1'b0, '0, '0);

    repeat (3) @(posedge clock_i);
    #5;
    chk("queue_drained", 320'(vq.size()), 320'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
